// File: rtl/boot_loader.sv
// Stream-driven program/data loader: decodes segment headers, writes payload words
// into the instruction or data BRAM, and holds the CPU stalled until a terminator header.
module boot_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned I_DEPTH    = 256,
    parameter int unsigned D_DEPTH    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  cpu_stall,
    output logic                  init_done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam int unsigned BASE_W = 15;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUM_W  = 17;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DONE,
        ERROR
    } state_t;

    state_t state, state_n;

    logic              seg_tgt, seg_tgt_n;
    logic [BASE_W-1:0] seg_base, seg_base_n;
    logic [CNT_W-1:0]  seg_cnt, seg_cnt_n;
    logic [CNT_W-1:0]  seg_idx, seg_idx_n;

    logic                  s_ready_n;
    logic [ADDR_WIDTH-1:0] i_w_addr_n, d_w_addr_n;
    logic [DATA_WIDTH-1:0] i_w_dat_n, d_w_dat_n;
    logic                  i_w_enb_n, d_w_enb_n;
    logic                  cpu_stall_n, init_done_n, error_n;
    logic [15:0]           words_n;

    // Header fields and the 17-bit bounds sum (cannot wrap)
    logic              xfer;
    logic              hdr_tgt;
    logic [BASE_W-1:0] hdr_base;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [SUM_W-1:0]  hdr_end;
    logic [SUM_W-1:0]  hdr_lim;
    logic [SUM_W-1:0]  wr_word;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign xfer     = s_valid && s_ready;
    assign hdr_tgt  = s_data[31];
    assign hdr_base = s_data[30:16];
    assign hdr_cnt  = s_data[15:0];
    assign hdr_end  = SUM_W'(hdr_base) + SUM_W'(hdr_cnt);
    assign hdr_lim  = hdr_tgt ? SUM_W'(D_DEPTH) : SUM_W'(I_DEPTH);
    assign wr_word  = SUM_W'(seg_base) + SUM_W'(seg_idx);
    assign wr_addr  = ADDR_WIDTH'({wr_word, 2'b00});

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_n    = state;
        seg_tgt_n  = seg_tgt;
        seg_base_n = seg_base;
        seg_cnt_n  = seg_cnt;
        seg_idx_n  = seg_idx;
        i_w_addr_n = i_w_addr;
        i_w_dat_n  = i_w_dat;
        i_w_enb_n  = 1'b0;
        d_w_addr_n = d_w_addr;
        d_w_dat_n  = d_w_dat;
        d_w_enb_n  = 1'b0;
        words_n    = words_loaded;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = HEADER;
                    words_n = '0;
                end
            end
            HEADER: begin
                if (xfer) begin
                    if (hdr_cnt == '0) begin
                        state_n = DONE;
                    end else if (hdr_end > hdr_lim) begin
                        state_n = ERROR;
                    end else begin
                        seg_tgt_n  = hdr_tgt;
                        seg_base_n = hdr_base;
                        seg_cnt_n  = hdr_cnt;
                        seg_idx_n  = '0;
                        state_n    = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (seg_tgt) begin
                        d_w_enb_n  = 1'b1;
                        d_w_addr_n = wr_addr;
                        d_w_dat_n  = s_data;
                    end else begin
                        i_w_enb_n  = 1'b1;
                        i_w_addr_n = wr_addr;
                        i_w_dat_n  = s_data;
                    end
                    seg_idx_n = CNT_W'(seg_idx + CNT_W'(1));
                    if (words_loaded != 16'hFFFF) begin
                        words_n = 16'(words_loaded + 16'd1);
                    end
                    if (CNT_W'(seg_idx + CNT_W'(1)) == seg_cnt) begin
                        state_n = HEADER;
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_n = HEADER;
                    words_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        s_ready_n   = (state_n == HEADER) || (state_n == PAYLOAD);
        cpu_stall_n = (state_n != DONE);
        init_done_n = (state_n == DONE);
        error_n     = (state_n == ERROR);
    end

    // State, segment context and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            seg_tgt      <= 1'b0;
            seg_base     <= '0;
            seg_cnt      <= '0;
            seg_idx      <= '0;
            s_ready      <= 1'b0;
            i_w_addr     <= '0;
            i_w_dat      <= '0;
            i_w_enb      <= 1'b0;
            d_w_addr     <= '0;
            d_w_dat      <= '0;
            d_w_enb      <= 1'b0;
            cpu_stall    <= 1'b1;
            init_done    <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            seg_tgt      <= seg_tgt_n;
            seg_base     <= seg_base_n;
            seg_cnt      <= seg_cnt_n;
            seg_idx      <= seg_idx_n;
            s_ready      <= s_ready_n;
            i_w_addr     <= i_w_addr_n;
            i_w_dat      <= i_w_dat_n;
            i_w_enb      <= i_w_enb_n;
            d_w_addr     <= d_w_addr_n;
            d_w_dat      <= d_w_dat_n;
            d_w_enb      <= d_w_enb_n;
            cpu_stall    <= cpu_stall_n;
            init_done    <= init_done_n;
            error        <= error_n;
            words_loaded <= words_n;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader: stimulus pushes expected BRAM writes,
// a negedge monitor pops and compares each write pulse, status is checked against a simple model.
module tb_boot_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned ID = 256;
    localparam int unsigned DD = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic [AW-1:0] i_w_addr, d_w_addr;
    logic [DW-1:0] i_w_dat, d_w_dat;
    logic          i_w_enb, d_w_enb;
    logic          cpu_stall, init_done, error;
    logic [15:0]   words_loaded;

    boot_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .I_DEPTH(ID), .D_DEPTH(DD)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .cpu_stall(cpu_stall), .init_done(init_done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            mem;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        int unsigned   cyc_at;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] ref_i[ID];
    logic [DW-1:0] ref_d[DD];
    logic [DW-1:0] got_i[ID];
    logic [DW-1:0] got_d[DD];
    int            checks = 0;
    int            errors = 0;
    int unsigned   exp_words = 0;
    bit            rand_valid = 0;

    // Monitor: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (rst && (i_w_enb || d_w_enb)) begin
            checks++;
            if (i_w_enb && d_w_enb) begin
                errors++;
                $display("FAIL both_enb: i_w_enb=1 d_w_enb=1, required at most one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: i_w_enb=%0b d_w_enb=%0b at cycle %0d, required no write",
                         i_w_enb, d_w_enb, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.mem != d_w_enb ||
                    (d_w_enb && (d_w_addr !== e.addr || d_w_dat !== e.dat)) ||
                    (i_w_enb && (i_w_addr !== e.addr || i_w_dat !== e.dat)) ||
                    cyc != e.cyc_at) begin
                    errors++;
                    $display("FAIL write: got mem=%0b addr=0x%03h dat=0x%08h cyc=%0d, required mem=%0b addr=0x%03h dat=0x%08h cyc=%0d",
                             d_w_enb, d_w_enb ? d_w_addr : i_w_addr, d_w_enb ? d_w_dat : i_w_dat, cyc,
                             e.mem, e.addr, e.dat, e.cyc_at);
                end
                if (i_w_enb) got_i[i_w_addr[AW-1:2]] = i_w_dat;
                if (d_w_enb) got_d[d_w_addr[AW-1:2]] = d_w_dat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Drive one word until it is accepted; 'at' is the cycle count just before the accepting edge
    task automatic send_word(input logic [31:0] w, output int unsigned at);
        int  waited = 0;
        bit  done = 0;
        at = 0;
        while (!done) begin
            @(negedge clk);
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_valid ? w : $urandom;
            if (s_valid && s_ready) begin
                done = 1;
                at   = cyc;
            end else if (++waited > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word 0x%08h not accepted in 100 cycles", w);
                done = 1;
            end
        end
    endtask

    task automatic push_write(input bit tgt, input int unsigned base, input int unsigned k,
                              input logic [31:0] w, input int unsigned at);
        wr_t e;
        e.mem    = tgt;
        e.addr   = AW'((base + k) * 4);
        e.dat    = w;
        e.cyc_at = at + 1;
        exp_q.push_back(e);
        if (tgt) ref_d[base + k] = w;
        else     ref_i[base + k] = w;
        if (exp_words < 32'hFFFF) exp_words++;
    endtask

    // Reference behaviour: terminator, out-of-bounds, or N payload writes
    task automatic send_segment(input bit tgt, input int unsigned base, input int unsigned n);
        int unsigned at;
        int unsigned lim;
        logic [31:0] w;
        send_word({tgt, 15'(base), 16'(n)}, at);
        lim = tgt ? DD : ID;
        if (n == 0 || base + n > lim) return;
        for (int k = 0; k < int'(n); k++) begin
            w = $urandom;
            send_word(w, at);
            push_write(tgt, base, k, w, at);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_words = 0;
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        repeat (n) begin
            @(negedge clk);
            s_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = $urandom;
        end
    endtask

    task automatic check_status(input string tag, input bit rdy, input bit stall,
                                input bit dn, input bit er);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'(rdy));
        chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(stall));
        chk({tag, "_init_done"}, 32'(init_done), 32'(dn));
        chk({tag, "_error"}, 32'(error), 32'(er));
        chk({tag, "_words_loaded"}, 32'(words_loaded), exp_words);
    endtask

    task automatic after_header(input string tag, input bit rdy, input bit stall,
                                input bit dn, input bit er);
        @(negedge clk);
        s_valid = 1'b0;
        check_status(tag, rdy, stall, dn, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned at;
        int unsigned tgt, n, base, lim;
        int          bad;

        for (int i = 0; i < int'(ID); i++) begin ref_i[i] = '0; got_i[i] = '0; end
        for (int i = 0; i < int'(DD); i++) begin ref_d[i] = '0; got_d[i] = '0; end

        // Reset values
        repeat (3) @(negedge clk);
        check_status("reset", 0, 1, 0, 0);
        chk("reset_i_w_enb", 32'(i_w_enb), 0);
        chk("reset_d_w_enb", 32'(d_w_enb), 0);
        chk("reset_i_w_addr", 32'(i_w_addr), 0);
        chk("reset_d_w_addr", 32'(d_w_addr), 0);
        chk("reset_i_w_dat", i_w_dat, 0);
        chk("reset_d_w_dat", d_w_dat, 0);
        rst = 1'b1;

        // IDLE ignores the stream until start
        idle_cycles(4, 1);
        chk("idle_s_ready", 32'(s_ready), 0);

        // Session 1: 14 instr words, 4 data words, terminator (back-to-back)
        pulse_start();
        check_status("start1", 1, 1, 0, 0);
        send_segment(0, 0, 14);
        send_segment(1, 0, 4);
        send_segment(0, 0, 0);
        after_header("done1", 0, 0, 1, 0);
        chk("done1_words18", 32'(words_loaded), 18);
        chk("done1_queue_empty", 32'(exp_q.size()), 0);

        // Session 2: single data word, random segments, gappy valid, boundary fit
        pulse_start();
        check_status("start2", 1, 1, 0, 0);
        send_word(32'h8003_0001, at);
        send_word(32'h0000_0006, at);
        push_write(1, 3, 0, 32'h0000_0006, at);
        rand_valid = 1;
        send_segment(0, 100, 4);
        for (int s = 0; s < 8; s++) begin
            tgt  = $urandom_range(0, 1);
            lim  = tgt ? DD : ID;
            n    = $urandom_range(1, 12);
            base = $urandom_range(0, lim - n);
            send_segment(tgt[0], base, n);
        end
        send_segment(0, 240, 16);
        rand_valid = 0;
        send_segment(1, 0, 0);
        after_header("done2", 0, 0, 1, 0);
        chk("done2_queue_empty", 32'(exp_q.size()), 0);

        // Out-of-bounds instr header, then restart clears error
        pulse_start();
        send_segment(0, 240, 32);
        after_header("err1", 0, 1, 0, 1);
        idle_cycles(6, 1);
        chk("err1_hold_error", 32'(error), 1);
        pulse_start();
        check_status("err1_restart", 1, 1, 0, 0);

        // Data bound one past the end
        send_segment(1, 255, 2);
        after_header("err2", 0, 1, 0, 1);
        pulse_start();
        check_status("err2_restart", 1, 1, 0, 0);

        // Async reset during the third word of a 4-word segment
        send_word({1'b0, 15'd16, 16'd4}, at);
        send_word(32'hA5A5_0000, at);
        push_write(0, 16, 0, 32'hA5A5_0000, at);
        send_word(32'hA5A5_0001, at);
        push_write(0, 16, 1, 32'hA5A5_0001, at);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0002;
        chk("pre_rst_i_w_enb", 32'(i_w_enb), 1);
        #2 rst = 1'b0;
        #1;
        exp_words = 0;
        check_status("mid_rst", 0, 1, 0, 0);
        chk("mid_rst_i_w_enb", 32'(i_w_enb), 0);
        chk("mid_rst_i_w_addr", 32'(i_w_addr), 0);
        chk("mid_rst_queue_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(6, 1);
        check_status("post_rst", 0, 1, 0, 0);

        // Empty session, then restart from DONE with an immediate terminator
        pulse_start();
        send_segment(0, 0, 0);
        after_header("done3", 0, 0, 1, 0);
        pulse_start();
        check_status("restart_done", 1, 1, 0, 0);
        send_segment(0, 0, 0);
        after_header("done4", 0, 0, 1, 0);

        // BRAM images built from write pulses must match the streamed data
        bad = 0;
        for (int i = 0; i < int'(ID); i++) if (ref_i[i] !== got_i[i]) bad++;
        chk("bram_i_contents", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < int'(DD); i++) if (ref_d[i] !== got_d[i]) bad++;
        chk("bram_d_contents", 32'(bad), 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Synthesizable program/data loader for the rv32i single-core.
- Accepts a valid/ready word stream of segment headers and payloads, and writes the payloads into the instruction BRAM or data BRAM write ports.
- Holds the PC stalled until a terminator header is seen, then releases the CPU.
- Replaces ad-hoc bench-side BRAM initialisation; parametrised in data width, address width and per-memory depth.

Parameters:
- DATA_WIDTH, 32, width of stream words and BRAM data.
- ADDR_WIDTH, 10, width of BRAM byte-address write ports.
- I_DEPTH, 256, instruction BRAM depth in words.
- D_DEPTH, 256, data BRAM depth in words.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle pulse; begins (or restarts) a load session.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  DATA_WIDTH  stream word (header or payload).
- i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address.
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data.
- i_w_enb  out  1  instruction BRAM write enable.
- d_w_addr  out  ADDR_WIDTH  data BRAM write byte address.
- d_w_dat  out  DATA_WIDTH  data BRAM write data.
- d_w_enb  out  1  data BRAM write enable.
- cpu_stall  out  1  drives pc stall; high while not DONE.
- init_done  out  1  load completed successfully.
- error  out  1  sticky segment-bounds error.
- words_loaded  out  16  total payload words written this session.

Behaviour:
- Reset (rst=0, async): state IDLE.
  - s_ready=0, all w_enb=0, all w_addr=0, all w_dat=0.
  - cpu_stall=1, init_done=0, error=0, words_loaded=0.
- Header format:
  - bit[31] = target (0=instr, 1=data).
  - bits[30:16] = base word index.
  - bits[15:0] = word count N.
- Handshake: a word transfers when s_valid && s_ready on a rising edge. s_valid may drop at any time without loss. The loader never backpressures inside a segment: s_ready=1 throughout HEADER and PAYLOAD.
- States:
  - IDLE: s_ready=0; start -> HEADER.
  - HEADER: on transfer:
    - N==0 -> DONE.
    - base+N > depth of target (I_DEPTH or D_DEPTH) -> ERROR.
    - otherwise latch target/base, clear the segment index, -> PAYLOAD.
  - PAYLOAD: each transfer with segment index k issues one write on the following cycle:
    - target w_enb=1 for exactly one cycle.
    - w_addr = (base+k)*4, truncated to ADDR_WIDTH.
    - w_dat = word.
    - the other memory's w_enb stays 0.
    - Write latency is 1 cycle from transfer.
    - words_loaded increments at the same edge.
    - After the Nth transfer -> HEADER. Back-to-back transfers produce back-to-back write pulses.
  - DONE: s_ready=0, cpu_stall=0, init_done=1. The final payload write completes before or at the cycle cpu_stall falls, never after.
  - ERROR: s_ready=0, error=1, cpu_stall=1, init_done=0. No further writes.
- Start handling:
  - start in DONE or ERROR -> HEADER. Next cycle cpu_stall=1, and init_done, error and words_loaded are cleared.
  - start in HEADER/PAYLOAD is ignored.
- Counter rules:
  - Segment index is 16 bits; the base+N bounds check uses a 17-bit sum, so there is no wrap.
  - words_loaded saturates at 16'hFFFF.
- Reset asserted mid-PAYLOAD: all outputs return to reset values immediately (async); no partial write pulse after deassertion.
- Addresses written are always word-aligned (w_addr[1:0]=0).

Test Plan:
- Reset, start, then stream headers 0x0000_000E (instr, base 0, N=14) + 14 words, 0x8000_0004 (data, base 0, N=4) + 4 words, 0x0000_0000 -> i_w_enb pulses with i_w_addr 0x000..0x034, d_w_enb pulses with d_w_addr 0x000..0x00C, words_loaded=18, cpu_stall falls and init_done=1 after the terminator; BRAM contents match the streamed words.
- Data segment header 0x8003_0001 + word 0x00000006 -> single d_w_enb pulse, d_w_addr=0x00C, d_w_dat=0x00000006, i_w_enb never asserted.
- Header 0x00F0_0020 (base 240 + 32 > 256) -> error=1, s_ready=0, cpu_stall stays 1, no write pulses; then start -> error=0, state HEADER.
- s_valid toggled randomly during a 4-word payload -> exactly 4 write pulses at consecutive addresses, each 1 cycle after its transfer, data in order.
- rst driven low during word 2 of a 4-word segment, async, mid-cycle -> outputs reset that same instant: i_w_enb=0, cpu_stall=1, words_loaded=0; after rst returns high, no writes until start.
- In DONE, pulse start and send header 0x0000_0000 -> cpu_stall high for the session, words_loaded=0, init_done reasserts.
